// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package arb_pkg;

    localparam int ARB_MAX_REQ = 32;
    localparam int ARB_ID_W    = $clog2(ARB_MAX_REQ);

    typedef enum logic {IDLE, OWNED} arb_state_t;

    // ORs together the indices of all set bits, which is the exact index for a one-hot input.
    function automatic logic [ARB_ID_W-1:0] onehot_idx(input logic [ARB_MAX_REQ-1:0] vec);
        logic [ARB_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (vec[i]) begin
                idx = idx | ARB_ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_chk.sv
// Combinational one-hot / all-zero classifier built on an unrolled population count.
module onehot_chk #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] vec,
    output logic                  is_onehot,
    output logic                  is_zero
);

    // One extra bit so an all-ones vector cannot wrap the count back to zero.
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

    assign is_onehot = (cnt == CNT_W'(1));
    assign is_zero   = (cnt == '0);

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a held one-hot grant and a sticky self-check on the grant vector.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic               err_clr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               err_sticky
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t           state, state_next;
    logic [ID_W-1:0]      ptr, ptr_next;
    logic [ID_W-1:0]      offset, winner, id_next;
    logic [ID_W:0]        sum;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot, gnt_next;
    logic                 gnt_onehot, gnt_zero, violation;

    // Rotate req so that bit 0 is the current priority holder, then take the lowest set bit.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = ID_W'(i);
            end
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, offset};
    assign winner = (sum > (ID_W+1)'(NUM_REQ - 1)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                   : sum[ID_W-1:0];

    // In OWNED the grant is rebuilt from gnt_id so the registered vector stays one-hot.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = OWNED;
                    gnt_next   = ONE << winner;
                end
            end
            OWNED: begin
                if (done) begin
                    state_next = IDLE;
                    ptr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                end else begin
                    gnt_next = ONE << gnt_id;
                end
            end
            default: state_next = IDLE;
        endcase
        id_next = ID_W'(onehot_idx(ARB_MAX_REQ'(gnt_next)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            gnt    <= gnt_next;
            gnt_id <= id_next;
        end
    end

    assign busy      = (state == OWNED);
    assign gnt_valid = |gnt;

    onehot_chk #(
        .DATA_WIDTH (NUM_REQ)
    ) u_chk (
        .vec        (gnt),
        .is_onehot  (gnt_onehot),
        .is_zero    (gnt_zero)
    );

    assign violation = busy ? !gnt_onehot : !gnt_zero;

    // A fresh violation wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (violation) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule
